// File: rtl/ovf_pkg.sv
// Shared types and saturation helpers for the overflow-detecting accumulator.
package ovf_pkg;

  typedef enum logic { OVF_UNSIGNED = 1'b0, OVF_SIGNED = 1'b1 } ovf_mode_e;
  typedef enum logic { OVF_POS = 1'b0, OVF_NEG = 1'b1 } ovf_dir_e;

  localparam logic [63:0] CNT_SAT = '1;

  // Largest representable value of a width-bit operand in the given mode (bit pattern).
  function automatic logic [63:0] sat_max(input int unsigned width, input ovf_mode_e mode);
    if (mode == OVF_SIGNED) return (64'(1) << (width - 1)) - 64'(1);
    else                    return (64'(1) << width) - 64'(1);
  endfunction

  // Most negative two's-complement value of a width-bit operand (bit pattern).
  function automatic logic [63:0] sat_min(input int unsigned width);
    return 64'(1) << (width - 1);
  endfunction

endpackage

// File: rtl/ovf_add_detect.sv
// Combinational adder with signed/unsigned overflow detection.
// Clamps instead of wrapping when OVF_SATURATE_EN is defined.
module ovf_add_detect
  import ovf_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic [WIDTH-1:0] sum,
  output logic             ovf,
  output ovf_dir_e         dir
);

  ovf_mode_e        mode;
  logic [WIDTH:0]   wide;
  logic [WIDTH-1:0] wrap;

  assign mode = ovf_mode_e'(is_signed);
  assign wide = {1'b0, a} + {1'b0, b};
  assign wrap = wide[WIDTH-1:0];

  always_comb begin
    ovf = 1'b0;
    dir = OVF_POS;
    if (mode == OVF_SIGNED) begin
      ovf = (a[WIDTH-1] == b[WIDTH-1]) && (wrap[WIDTH-1] != a[WIDTH-1]);
      // Signed overflow only occurs with like-signed operands, so a's sign gives the direction.
      dir = a[WIDTH-1] ? OVF_NEG : OVF_POS;
    end else begin
      ovf = wide[WIDTH];
    end
  end

`ifdef OVF_SATURATE_EN
  always_comb begin
    sum = wrap;
    if (ovf) begin
      if (mode == OVF_SIGNED)
        sum = (dir == OVF_NEG) ? WIDTH'(sat_min(WIDTH)) : WIDTH'(sat_max(WIDTH, OVF_SIGNED));
      else
        sum = WIDTH'(sat_max(WIDTH, OVF_UNSIGNED));
    end
  end
`else
  assign sum = wrap;
`endif

endmodule

// File: rtl/ovf_accumulator.sv
// Running-sum accumulator with per-sample/sticky overflow and a saturating event counter.
// Saturating results are selected by defining OVF_SATURATE_EN.
module ovf_accumulator
  import ovf_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             is_signed,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] acc,
  output logic             ovf,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] ovf_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CNT_SAT);

  logic             accept;
  logic [WIDTH-1:0] add_sum;
  logic             add_ovf;
  ovf_dir_e         dir_unused;

  assign in_ready = ~clr & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;

  ovf_add_detect #(.WIDTH(WIDTH)) u_add (
    .a         (acc),
    .b         (in_data),
    .is_signed (is_signed),
    .sum       (add_sum),
    .ovf       (add_ovf),
    .dir       (dir_unused)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      ovf        <= 1'b0;
      ovf_sticky <= 1'b0;
      ovf_cnt    <= '0;
      out_valid  <= 1'b0;
    end else if (clr) begin
      acc        <= '0;
      ovf        <= 1'b0;
      ovf_sticky <= 1'b0;
      ovf_cnt    <= '0;
      out_valid  <= 1'b0;
    end else if (accept) begin
      acc       <= add_sum;
      ovf       <= add_ovf;
      out_valid <= 1'b1;
      if (add_ovf) begin
        ovf_sticky <= 1'b1;
        if (ovf_cnt != CNT_MAX) ovf_cnt <= ovf_cnt + 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ovf_accumulator.sv
// Randomized and directed checks of ovf_accumulator against an integer-arithmetic reference model.
module tb_ovf_accumulator;

  localparam int W    = 8;
  localparam int M    = 2 ** W;
  localparam int HALF = 2 ** (W - 1);

  logic         clk = 1'b0;
  logic         rst_n, clr, is_signed, in_valid, out_ready;
  logic         in_ready, out_valid, ovf, ovf_sticky;
  logic [W-1:0] in_data, acc;
  logic [7:0]   ovf_cnt;

  int checks = 0;
  int errors = 0;

  int m_acc, m_cnt;
  bit m_ovf, m_sticky, m_ov;

  ovf_accumulator #(.WIDTH(W), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .is_signed  (is_signed),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .acc        (acc),
    .ovf        (ovf),
    .ovf_sticky (ovf_sticky),
    .ovf_cnt    (ovf_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: treat operands as mathematical integers, then range-check the true sum.
  function automatic void model_add(input int a, input int b, input bit sgn,
                                    output int res, output bit flag);
    int sa, sb, sum;
    sa = (sgn && a >= HALF) ? a - M : a;
    sb = (sgn && b >= HALF) ? b - M : b;
    sum = sa + sb;
    flag = sgn ? (sum > HALF - 1 || sum < -HALF) : (sum > M - 1);
    res = ((sum % M) + M) % M;
`ifdef OVF_SATURATE_EN
    if (flag) res = sgn ? (sum > 0 ? HALF - 1 : HALF) : M - 1;
`endif
  endfunction

  task automatic model_reset();
    m_acc = 0; m_ovf = 0; m_sticky = 0; m_cnt = 0; m_ov = 0;
  endtask

  task automatic check_outputs(input string pfx);
    check({pfx, ".acc"},       32'(acc),        32'(m_acc));
    check({pfx, ".ovf"},       32'(ovf),        32'(m_ovf));
    check({pfx, ".sticky"},    32'(ovf_sticky), 32'(m_sticky));
    check({pfx, ".cnt"},       32'(ovf_cnt),    32'(m_cnt));
    check({pfx, ".out_valid"}, 32'(out_valid),  32'(m_ov));
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic cyc(input bit c, input bit s, input bit v, input int d, input bit r);
    bit exp_ready, accept, flag;
    int res;
    clr = c; is_signed = s; in_valid = v; in_data = W'(d); out_ready = r;
    #1;
    exp_ready = !c && (!m_ov || r);
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    accept = v && exp_ready;
    if (c) begin
      model_reset();
    end else if (accept) begin
      model_add(m_acc, d, s, res, flag);
      m_acc = res; m_ovf = flag; m_ov = 1;
      if (flag) begin
        m_sticky = 1;
        if (m_cnt != 255) m_cnt++;
      end
    end else if (m_ov && r) begin
      m_ov = 0;
    end
    @(posedge clk); #1;
    check_outputs("cyc");
    @(negedge clk);
  endtask

  initial begin
    rst_n = 0; clr = 0; is_signed = 0; in_valid = 0; in_data = '0; out_ready = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs("reset");
    rst_n = 1;
    @(negedge clk);

    // Signed positive wrap: 0x70 + 0x20
    cyc(1, 0, 0, 0, 1);
    cyc(0, 0, 1, 'h70, 1);
    cyc(0, 1, 1, 'h20, 1);
`ifdef OVF_SATURATE_EN
    check("t1.acc", 32'(acc), 32'h7F);
`else
    check("t1.acc", 32'(acc), 32'h90);
`endif
    check("t1.ovf", 32'(ovf), 1);
    check("t1.cnt", 32'(ovf_cnt), 1);

    // Unsigned carry: 0xF0 + 0x20, then +0x01
    cyc(1, 0, 0, 0, 1);
    cyc(0, 0, 1, 'hF0, 1);
    cyc(0, 0, 1, 'h20, 1);
`ifdef OVF_SATURATE_EN
    check("t2.acc", 32'(acc), 32'hFF);
`else
    check("t2.acc", 32'(acc), 32'h10);
`endif
    check("t2.ovf", 32'(ovf), 1);
    cyc(0, 0, 1, 'h01, 1);
`ifndef OVF_SATURATE_EN
    check("t2.ovf_next", 32'(ovf), 0);
`endif
    check("t2.sticky", 32'(ovf_sticky), 1);

    // Signed negative overflow, then mixed signs
    cyc(1, 0, 0, 0, 1);
    cyc(0, 0, 1, 'h80, 1);
    cyc(0, 1, 1, 'hFF, 1);
`ifdef OVF_SATURATE_EN
    check("t3.acc", 32'(acc), 32'h80);
`else
    check("t3.acc", 32'(acc), 32'h7F);
`endif
    check("t3.ovf", 32'(ovf), 1);
    cyc(1, 0, 0, 0, 1);
    cyc(0, 0, 1, 'h7F, 1);
    cyc(0, 1, 1, 'h80, 1);
    check("t3.mixed_acc", 32'(acc), 32'hFF);
    check("t3.mixed_ovf", 32'(ovf), 0);

    // Backpressure, then full-throughput drain
    for (int unsigned i = 0; i < 3; i++) cyc(0, 0, 1, 'h11 + i, 0);
    for (int unsigned i = 0; i < 4; i++) cyc(0, 0, 1, 'h03 + i, 1);

    // Clear collides with a valid input and a pending result
    cyc(0, 0, 1, 'h05, 0);
    cyc(1, 0, 1, 'h33, 0);
    check("t5.acc", 32'(acc), 0);
    check("t5.out_valid", 32'(out_valid), 0);

    // Randomized traffic
    for (int unsigned i = 0; i < 1500; i++)
      cyc($urandom_range(0, 49) == 0, 1'($urandom), $urandom_range(0, 3) != 0,
          int'($urandom_range(0, 255)), $urandom_range(0, 3) != 0);

    // Counter saturation: adding 0xFF unsigned to nonzero acc always carries
    cyc(1, 0, 0, 0, 1);
    for (int unsigned i = 0; i < 301; i++) cyc(0, 0, 1, 'hFF, 1);
    check("t6.cnt_sat", 32'(ovf_cnt), 32'hFF);

    // Asynchronous reset mid-stream
    in_valid = 1; in_data = 'h42; out_ready = 0;
    #2 rst_n = 0;
    #1;
    model_reset();
    check_outputs("async_reset");
    @(negedge clk);
    in_valid = 0;
    rst_n = 1;
    cyc(0, 0, 1, 'h21, 1);
    check("post_reset.acc", 32'(acc), 32'h21);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
